// File: rtl/msj_motor_pwm_out_if.sv
// Bus between the PID stage and the multi-channel PWM generator.
// The PID stage (master) drives duty/ena/mute. The PWM block (slave) returns pulses and status.
interface msj_motor_pwm_out_if #(
    parameter int NUMBER_OF_MOTORS = 8
);
    // Handshake: ena[i] is a one-cycle valid strobe for duty word i.
    // There is no ready; the slave accepts every strobe in the cycle it is presented.
    logic                            mute;
    logic [NUMBER_OF_MOTORS-1:0]     ena;
    logic [32*NUMBER_OF_MOTORS-1:0]  duty;
    logic [NUMBER_OF_MOTORS-1:0]     pwm_out;
    logic                            period_start;
    logic [NUMBER_OF_MOTORS-1:0]     watchdog_tripped;

    modport master (
        output mute,
        output ena,
        output duty,
        input  pwm_out,
        input  period_start,
        input  watchdog_tripped
    );

    modport slave (
        input  mute,
        input  ena,
        input  duty,
        output pwm_out,
        output period_start,
        output watchdog_tripped
    );
endinterface

// File: rtl/msj_motor_pwm_out.sv
// Multi-channel servo/ESC PWM generator with shadowed, clamped duty registers.
// Define MSJ_PWM_WATCHDOG_EN to build the per-channel watchdog that falls back to SAFE_DUTY.
module msj_motor_pwm_out #(
    parameter int NUMBER_OF_MOTORS = 8,
    parameter int CLOCK_SPEED_HZ   = 50_000_000,
    parameter int PWM_FREQ_HZ      = 50,
    parameter int RESOLUTION_BITS  = 12,
    parameter int SAFE_DUTY        = 330,
    parameter int WATCHDOG_PERIODS = 5
) (
    input logic                clock,
    input logic                reset,
    msj_motor_pwm_out_if.slave bus
);
    localparam int PERIOD_TICKS = 2 ** RESOLUTION_BITS;
    localparam int DIV          = CLOCK_SPEED_HZ / (PWM_FREQ_HZ * PERIOD_TICKS);
    localparam int PRE_W        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MAX_DUTY     = PERIOD_TICKS - 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam int SAFE_INT     = (SAFE_DUTY < 0) ? 0 :
                                  (SAFE_DUTY > MAX_DUTY) ? MAX_DUTY : SAFE_DUTY;
    localparam logic [RESOLUTION_BITS-1:0] SAFE_CLAMPED = RESOLUTION_BITS'(SAFE_INT);

    if (DIV < 1) begin : g_div_check
        $error("msj_motor_pwm_out: CLOCK_SPEED_HZ too low for PWM_FREQ_HZ and RESOLUTION_BITS");
    end
    if (WATCHDOG_PERIODS < 1) begin : g_wd_check
        $error("msj_motor_pwm_out: WATCHDOG_PERIODS must be at least 1");
    end

    function automatic logic [RESOLUTION_BITS-1:0] clamp_duty(input logic signed [31:0] d);
        if (d < 0)
            clamp_duty = '0;
        else if (d > MAX_DUTY)
            clamp_duty = '1;
        else
            clamp_duty = d[RESOLUTION_BITS-1:0];
    endfunction

    logic [PRE_W-1:0]           prescaler;
    logic [RESOLUTION_BITS-1:0] cnt;
    logic                       tick;
    logic                       boundary;
    logic                       start;

    assign tick     = (prescaler == PRE_LAST);
    assign boundary = tick && (cnt == '1);
    assign start    = (prescaler == '0) && (cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            cnt       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                cnt <= cnt + 1'b1;
        end
    end

    logic [RESOLUTION_BITS-1:0] clamped [NUMBER_OF_MOTORS];

    always_comb begin
        for (int i = 0; i < NUMBER_OF_MOTORS; i++)
            clamped[i] = clamp_duty(bus.duty[32*i +: 32]);
    end

    // trip[i] is high only in the boundary cycle where channel i falls back to SAFE_DUTY
    logic [NUMBER_OF_MOTORS-1:0] trip;

`ifdef MSJ_PWM_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_PERIODS + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_PERIODS - 1);
    localparam logic [WD_W-1:0] WD_SAT  = WD_W'(WATCHDOG_PERIODS);

    logic [WD_W-1:0]             wd [NUMBER_OF_MOTORS];
    logic [NUMBER_OF_MOTORS-1:0] tripped;

    always_comb begin
        trip = '0;
        for (int i = 0; i < NUMBER_OF_MOTORS; i++)
            trip[i] = boundary && !bus.ena[i] && (wd[i] == WD_LAST);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++)
                wd[i] <= '0;
            tripped <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                if (bus.ena[i]) begin
                    wd[i]      <= '0;
                    tripped[i] <= 1'b0;
                end else if (boundary && (wd[i] != WD_SAT)) begin
                    wd[i] <= wd[i] + 1'b1;
                    if (trip[i])
                        tripped[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.watchdog_tripped = tripped;
`else
    assign trip                 = '0;
    assign bus.watchdog_tripped = '0;
`endif

    logic [RESOLUTION_BITS-1:0] shadow [NUMBER_OF_MOTORS];
    logic [RESOLUTION_BITS-1:0] active [NUMBER_OF_MOTORS];

    // A strobe in the boundary cycle bypasses shadow so the next period already uses it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUMBER_OF_MOTORS; i++) begin
                if (bus.ena[i]) begin
                    shadow[i] <= clamped[i];
                    if (boundary)
                        active[i] <= clamped[i];
                end else if (trip[i]) begin
                    shadow[i] <= SAFE_CLAMPED;
                    active[i] <= SAFE_CLAMPED;
                end else if (boundary) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    logic [NUMBER_OF_MOTORS-1:0] pwm_q;
    logic                        start_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_q   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            for (int i = 0; i < NUMBER_OF_MOTORS; i++)
                pwm_q[i] <= (cnt < active[i]) && !bus.mute;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = start_q;
endmodule

// File: tb/tb_msj_motor_pwm_out.sv
// Directed bench for msj_motor_pwm_out: 4 channels, DIV=4, 16-step period (64 clocks).
// Runs the watchdog sequence when MSJ_PWM_WATCHDOG_EN is defined, otherwise the core sequence.
module tb_msj_motor_pwm_out;
    localparam int NM     = 4;
    localparam int DIV    = 4;
    localparam int PERIOD = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;

    msj_motor_pwm_out_if #(.NUMBER_OF_MOTORS(NM)) bus ();

    msj_motor_pwm_out #(
        .NUMBER_OF_MOTORS(NM),
        .CLOCK_SPEED_HZ  (64),
        .PWM_FREQ_HZ     (1),
        .RESOLUTION_BITS (4),
        .SAFE_DUTY       (3),
        .WATCHDOG_PERIODS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full output period. w* are hand-computed active duties (in steps) for the period.
    // Up to two ena strobes (offset, channel, duty) and one mute window are applied.
    task automatic run_period(input string tag,
                              input int w0, input int w1, input int w2, input int w3,
                              input int ia_k, input int ia_ch, input int ia_d,
                              input int ib_k, input int ib_ch, input int ib_d,
                              input int m_k, input int m_len);
        int   w [NM];
        int   bad [NM];
        int   ps_bad;
        logic muted;
        logic exp_bit;
        w      = '{w0, w1, w2, w3};
        bad    = '{0, 0, 0, 0};
        ps_bad = 0;
        for (int k = 0; k < PERIOD; k++) begin
            bus.ena = '0;
            if (k == ia_k) begin
                bus.ena[ia_ch]            = 1'b1;
                bus.duty[32*ia_ch +: 32] = ia_d;
            end
            if (k == ib_k) begin
                bus.ena[ib_ch]            = 1'b1;
                bus.duty[32*ib_ch +: 32] = ib_d;
            end
            muted    = (k >= m_k) && (k < m_k + m_len);
            bus.mute = muted;
            @(posedge clock);
            #1;
            for (int i = 0; i < NM; i++) begin
                exp_bit = (k < w[i] * DIV) && !muted;
                if (bus.pwm_out[i] !== exp_bit)
                    bad[i]++;
            end
            if (bus.period_start !== (k == 0))
                ps_bad++;
        end
        bus.ena  = '0;
        bus.mute = 1'b0;
        for (int i = 0; i < NM; i++)
            check($sformatf("%s pwm%0d bad cycles", tag, i), bad[i], 0);
        check($sformatf("%s period_start bad cycles", tag), ps_bad, 0);
    endtask

    initial begin
        bus.mute = 1'b0;
        bus.ena  = '0;
        bus.duty = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset pwm_out", bus.pwm_out, 0);
        check("reset period_start", bus.period_start, 0);
        check("reset watchdog_tripped", bus.watchdog_tripped, 0);
        reset = 1'b0;

`ifdef MSJ_PWM_WATCHDOG_EN
        run_period("w0_latch10", 0, 0, 0, 0, 30, 0, 10, -1, 0, 0, -1, 0);
        check("w0 tripped", bus.watchdog_tripped, 4'h0);
        run_period("w1_duty10", 10, 0, 0, 0, -1, 0, 0, -1, 0, 0, -1, 0);
        check("w1 tripped", bus.watchdog_tripped, 4'hF);
        run_period("w2_safe", 3, 3, 3, 3, 20, 0, 6, -1, 0, 0, -1, 0);
        check("w2 tripped", bus.watchdog_tripped, 4'hE);
        run_period("w3_duty6", 6, 3, 3, 3, 63, 0, 9, -1, 0, 0, -1, 0);
        check("w3 ena beats trip", bus.watchdog_tripped, 4'hE);
        run_period("w4_bypass9", 9, 3, 3, 3, -1, 0, 0, -1, 0, 0, -1, 0);
        check("w4 tripped", bus.watchdog_tripped, 4'hE);
        run_period("w5_duty9", 9, 3, 3, 3, -1, 0, 0, -1, 0, 0, -1, 0);
        check("w5 retrip", bus.watchdog_tripped, 4'hF);
        run_period("w6_safe", 3, 3, 3, 3, -1, 0, 0, -1, 0, 0, -1, 0);
`else
        run_period("p0_idle", 0, 0, 0, 0, 30, 0, 5, -1, 0, 0, -1, 0);
        run_period("p1_duty5", 5, 0, 0, 0, 10, 1, -7, -1, 0, 0, -1, 0);
        run_period("p2_neg_clamp", 5, 0, 0, 0, 20, 1, 1000, -1, 0, 0, -1, 0);
        run_period("p3_hi_clamp", 5, 15, 0, 0, 63, 2, 8, -1, 0, 0, -1, 0);
        run_period("p4_mute", 5, 15, 8, 0, 10, 3, 2, 40, 3, 3, 6, 3);
        run_period("p5_last_wins", 5, 15, 8, 3, 2, 0, 1, -1, 0, 0, -1, 0);
        run_period("p6_shadowed", 1, 15, 8, 3, 5, 2, 16, 63, 3, 0, -1, 0);
        run_period("p7_bypass_zero", 1, 15, 15, 0, -1, 0, 0, -1, 0, 0, -1, 0);
        check("no watchdog tripped", bus.watchdog_tripped, 4'h0);
`endif

        @(posedge clock);
        #1;
        check("pre-reset pwm1 high", bus.pwm_out[1], 1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset pwm_out", bus.pwm_out, 0);
        check("async reset period_start", bus.period_start, 0);
        check("async reset watchdog_tripped", bus.watchdog_tripped, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/msj_motor_pwm_out.md
Name: msj_motor_pwm_out

Overview:
Multi-channel servo/ESC pulse generator that directly consumes the per-motor duty words and cycle strobes produced by the MSJ platform PID stage.
- Shared prescaler and period counter for all channels.
- Per-channel shadow and active duty registers, so duty changes only take effect at a period boundary and never glitch a pulse.
- Duty clamping, a global mute, and an optional per-channel watchdog that falls back to a safe duty.

Parameters:
NUMBER_OF_MOTORS, 8, number of PWM channels
CLOCK_SPEED_HZ, 50_000_000, system clock frequency
PWM_FREQ_HZ, 50, PWM period frequency
RESOLUTION_BITS, 12, period length is 2^RESOLUTION_BITS ticks
SAFE_DUTY, 330, watchdog fallback duty in ticks
WATCHDOG_PERIODS, 5, period boundaries without ena before watchdog trips

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
mute  in  1  synchronous; forces all pwm_out low
ena  in  NUMBER_OF_MOTORS  bit i: 1-cycle strobe that latches duty word i into shadow i
duty  in  32*NUMBER_OF_MOTORS  signed duty words; channel i occupies bits [32i+31:32i]
pwm_out  out  NUMBER_OF_MOTORS  pulse outputs
period_start  out  1  1-cycle pulse in the first clock of every period
watchdog_tripped  out  NUMBER_OF_MOTORS  channel running on SAFE_DUTY

Behaviour:
Timing:
- DIV = CLOCK_SPEED_HZ / (PWM_FREQ_HZ * 2^RESOLUTION_BITS), integer-truncated; must be >= 1, enforced by elaboration-time check.
- Prescaler counts 0..DIV-1; tick = (prescaler == DIV-1).
- cnt (RESOLUTION_BITS wide) increments on tick and wraps 2^B-1 -> 0.
- boundary = tick && cnt == 2^B-1.
- period_start = 1 when prescaler == 0 && cnt == 0, registered.
  - First assertion is in the first clock after reset release.
  - Period length = DIV * 2^B clocks.

Duty clamp (applied on latch):
- duty < 0 -> 0.
- duty > 2^B-1 -> 2^B-1.
- Otherwise duty[B-1:0].

Shadow and active registers:
- ena[i] loads clamped duty into shadow[i] in the same cycle.
- On boundary, active[i] <= shadow[i].
- ena[i] coincident with boundary: the new clamped value goes straight into active[i] (bypass), so the following period uses it.
- Multiple ena strobes within one period: the last one wins.

Output:
- pwm_out[i] registered = (cnt < active[i]) && !mute.
- Output lags period_start by 0 clocks; it rises in the same cycle period_start is asserted.
- active = 0: output constantly low.
- active = 2^B-1: high for (2^B-1)*DIV clocks, low for DIV clocks; never 100%.

Mute:
- pwm_out goes low on the clock after mute is sampled high.
- Shadow, active and counters keep running while muted.
- On mute release, output resumes from the current cnt comparison on the next clock; there is no realignment.

Reset:
- pwm_out = 0, period_start = 0, watchdog_tripped = 0.
- prescaler, cnt, shadow and active = 0.
- Reset asserted mid-pulse drops the output immediately (asynchronous).

Optional Feature:
Macro: MSJ_PWM_WATCHDOG_EN.

With the macro defined:
- Per-channel counter wd[i] counts boundaries since the last ena[i], saturating at WATCHDOG_PERIODS.
- ena[i] clears wd[i] and watchdog_tripped[i].
- At the boundary where wd[i] reaches WATCHDOG_PERIODS:
  - shadow[i] and active[i] are loaded with clamped SAFE_DUTY, which overrides the normal shadow->active transfer.
  - watchdog_tripped[i] is set.
- ena[i] in the same cycle as the trip boundary takes priority: bypass load, no trip.
- Reset clears wd and watchdog_tripped.

Without the macro:
- No watchdog counters are built.
- watchdog_tripped is tied to 0.

Test Plan:
All scenarios use CLOCK_SPEED_HZ=64, PWM_FREQ_HZ=1, RESOLUTION_BITS=4, giving DIV=4 and a 64-clock period. Scenario 6 additionally uses SAFE_DUTY=3 and WATCHDOG_PERIODS=2.

1. Release reset, no ena -> period_start pulses at clocks 0, 64, 128, ...; all pwm_out stay 0; watchdog_tripped stays 0 until the feature trips.
2. ena[0] with duty=5 at clock 30 -> period at clock 64: pwm_out[0] high for 20 clocks, then low for 44; other channels stay 0.
3. ena[1] with duty=-7 -> pwm_out[1] constantly low. Then duty=1000 -> high 60 clocks, low 4 clocks per period.
4. ena[2] with duty=8 in the boundary cycle (clock 63) -> the period starting at clock 64 already shows a 32-clock pulse.
5. Channel 0 at duty 5; assert mute at clock 70 for 3 clocks -> pwm_out[0] low at clocks 71-73, high again at clock 74 until clock 84; next period still shows a 20-clock pulse.
6. Watchdog (macro defined): after one ena with duty=10, no further ena -> after 2 boundaries, pwm_out shows 12-clock pulses and watchdog_tripped=1. A new ena with duty=6 clears the flag, and the next period shows a 24-clock pulse.
